// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART bootloader: loader FSM state encoding and
// the frame sync byte.
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, with a 2-FF input synchronizer, start-bit
// glitch rejection and mid-bit sampling.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   rxd       in   serial input, idle high, asynchronous to clk
//   rx_data   out  received byte, valid while rx_valid is high
//   rx_valid  out  1-cycle pulse, the cycle after the stop-bit sample
//   rx_ferr   out  qualifies rx_valid: stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // sync1/sync2 form the synchronizer; sync3 is the previous synced value
    // used only for falling-edge detection.
    logic          sync1_q, sync2_q, sync3_q;
    logic          busy_q,  busy_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [3:0]    bit_q,   bit_d;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;
    logic          ferr_q,  ferr_d;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;

        if (!busy_q) begin
            if (sync3_q && !sync2_q) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                bit_d  = 4'd0;
            end
        end else if (bit_q == 4'd0) begin
            // Half a bit after the edge: a high line means it was a glitch.
            if (cnt_q == CNT_HALF) begin
                cnt_d = '0;
                if (sync2_q) busy_d = 1'b0;
                else         bit_d  = 4'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                // Stop-bit sample: go idle at once so a start bit right
                // behind this stop bit is caught.
                busy_d  = 1'b0;
                bit_d   = 4'd0;
                valid_d = 1'b1;
                ferr_d  = !sync2_q;
                data_d  = shift_q;
            end else begin
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
// UART bootloader: receives 55 LEN_LO LEN_HI <N data> CSUM, writes the data
// bytes into code memory from address 0 and keeps the CPU held until a frame
// with a matching 8-bit checksum has been fully written.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rxd        in   UART receive line, idle high
//   mem_we     out  1-cycle code memory write strobe
//   mem_addr   out  code memory write address
//   mem_wdata  out  code memory write data
//   cpu_hold   out  high in every state except DONE
//   load_done  out  high in DONE
//   load_err   out  high in ERR
// -----------------------------------------------------------------------------
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ   = 12_000_000,
    parameter int BAUD     = 115200,
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [16:0] MEM_SIZE_L = 17'(MEM_SIZE);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    state_e            state_q,  state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       rem_q,    rem_d;     // data bytes still expected
    logic [7:0]        sum_q,    sum_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              we_q,     we_d;
    logic [7:0]        wdata_q,  wdata_d;
    logic [15:0]       n_len;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        n_len    = {rx_data, len_lo_q};

        // Address advances the cycle after the strobe, so it is stable
        // during the write itself.
        if (we_q) addr_d = addr_q + ADDR_W'(1);

        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (!rx_ferr && rx_data == SYNC_BYTE) state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (rx_ferr) begin
                        state_d = ST_ERR;
                    end else begin
                        len_lo_d = rx_data;
                        state_d  = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_ferr) begin
                        state_d = ST_ERR;
                    end else begin
                        rem_d  = n_len;
                        sum_d  = 8'h00;
                        addr_d = '0;
                        if ({1'b0, n_len} > MEM_SIZE_L) state_d = ST_ERR;
                        else if (n_len == 16'd0)        state_d = ST_CSUM;
                        else                            state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_ferr) begin
                        state_d = ST_ERR;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = rx_data;
                        sum_d   = sum_q + rx_data;
                        rem_d   = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (!rx_ferr && rx_data == sum_q) state_d = ST_DONE;
                    else                              state_d = ST_ERR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_lo_q <= 8'h00;
            rem_q    <= 16'd0;
            sum_q    <= 8'h00;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = (state_q != ST_DONE);
    assign load_done = (state_q == ST_DONE);
    assign load_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader
// Directed frames on rxd; expected memory writes are queued as they are sent
// and a negedge monitor pops and compares them whenever mem_we is high.
// -----------------------------------------------------------------------------
module tb_uart_loader;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_HZ / BAUD;   // 16 clocks per bit
    localparam int MEM_SIZE = 1024;
    localparam int ADDR_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rxd = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    logic prev_we = 1'b0;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t exp_q[$];

    uart_loader #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .MEM_SIZE(MEM_SIZE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mem_we) begin
            n_writes++;
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got %0h@%0h, expected no write", mem_wdata, mem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                check("write_data", {24'd0, mem_wdata}, {24'd0, e.data});
            end
        end
        prev_we = mem_we;
    end

    task automatic push_w(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
        @(negedge clk);
        check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
        check({tag, "_load_err"},  {31'd0, load_err},  {31'd0, err});
        check({tag, "_cpu_hold"},  {31'd0, cpu_hold},  {31'd0, hold});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        check({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd1);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_load_err"},  {31'd0, load_err},  32'd0);
    endtask

    initial begin
        // Reset
        repeat (4) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_released");

        // Idle line: no writes
        idle_bits(20);
        check("idle_no_write", n_writes, 0);

        // Good load, back-to-back bytes
        push_w(16'd0, 8'hA9);
        push_w(16'd1, 8'h01);
        push_w(16'd2, 8'h00);
        send_byte(8'h55); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'hA9); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA);
        check_status("good", 1'b1, 1'b0, 1'b0);
        check("good_write_count", n_writes, 3);

        // Bad checksum (sum 0x30), then a good frame
        push_w(16'd0, 8'h10);
        push_w(16'd1, 8'h20);
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1);
        push_w(16'd0, 8'h5A);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h5A); send_byte(8'h5A);
        check_status("recover", 1'b1, 1'b0, 1'b0);

        // Length overflow N=1025, then N=0 frame
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h04);
        check_status("overflow", 1'b0, 1'b1, 1'b1);
        check("overflow_no_write", n_writes, 6);
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check_status("zero_len", 1'b1, 1'b0, 1'b0);

        // Framing error on second data byte
        push_w(16'd0, 8'h77);
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h77); send_byte(8'h88, 1'b0);
        idle_bits(1);
        check_status("ferr", 1'b0, 1'b1, 1'b1);
        check("ferr_write_count", n_writes, 7);

        // 3-clock glitch inside a frame must not be taken as a data byte
        push_w(16'd0, 8'h42);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00);
        idle_bits(1);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(2);
        send_byte(8'h42); send_byte(8'h42);
        check_status("glitch", 1'b1, 1'b0, 1'b0);
        check("glitch_write_count", n_writes, 8);

        // Reset during DATA byte 2 of a 5-byte image
        push_w(16'd0, 8'h11);
        send_byte(8'h55); send_byte(8'h05); send_byte(8'h00); send_byte(8'h11);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_rst");
        rxd = 1'b1;
        rst = 1'b0;
        idle_bits(2);
        check_reset_outputs("after_rst");
        push_w(16'd0, 8'h33);
        push_w(16'd1, 8'h44);
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h77);
        check_status("fresh", 1'b1, 1'b0, 1'b0);

        idle_bits(2);
        check("pending_writes", exp_q.size(), 0);
        check("total_writes", n_writes, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

UART bootloader for the single-clock 6502 system. Receives a framed program image on `UART_RXD`, writes it byte-by-byte into the code memory starting at address 0, and holds the CPU stalled until a complete image with a valid checksum has been written. It is the receiving end of the host-side program download and sits between the board UART pin and the write port of `code_mem`.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency in Hz
- `BAUD`, 115200, UART bit rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer, must be ≥ 8)
- `MEM_SIZE`, 1024, code memory depth in bytes
- `ADDR_W`, 16, width of `mem_addr`

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rxd`  in  1  UART receive line, idle high, asynchronous to `clk`
- `mem_we`  out  1  one-cycle write strobe to code memory
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  8  write data
- `cpu_hold`  out  1  high = CPU must not run (held in reset/stall)
- `load_done`  out  1  high after a valid image is loaded
- `load_err`  out  1  high after a failed load, until the next sync byte

## Operation
- Frame: sync byte 0x55, LEN_LO, LEN_HI (length N, little-endian), N data bytes, CSUM = sum of data bytes mod 256.
- UART format 8N1, LSB first. `rxd` passes through a 2-FF synchronizer before use.
- Receiver: falling edge on synced line starts a bit counter; start bit re-sampled at CLKS_PER_BIT/2, low confirms start, high returns to idle (glitch rejection). Data bits sampled at mid-bit, stop bit sampled at mid-bit. Stop = 0 flags a framing error for that byte.
- Loader FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - IDLE: non-0x55 bytes and framing errors ignored; 0x55 → LEN_LO.
  - LEN_LO → LEN_HI → if N > MEM_SIZE → ERR; N = 0 → CSUM; else → DATA with address 0, running sum 0.
  - DATA: each byte written to `mem_addr` then address increments; sum += byte (8-bit wrap); after byte N → CSUM.
  - CSUM: received byte == sum → DONE, else → ERR.
  - DONE / ERR: 0x55 → LEN_LO (restart load); other bytes ignored.
  - Framing error in LEN_LO, LEN_HI, DATA or CSUM → ERR immediately; byte discarded, no write.
- `cpu_hold` = 1 in every state except DONE. `load_done` = 1 only in DONE. `load_err` = 1 only in ERR.
- Memory beyond N keeps its previous contents; a failed load may leave a partial image (CPU stays held).

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0; FSM IDLE; receiver idle. Reset mid-byte or mid-frame discards everything in progress.
- Internal byte-valid pulse: 1 cycle, asserted the cycle after the stop-bit sample.
- `mem_we` asserted exactly 1 cycle after byte-valid, with `mem_addr`/`mem_wdata` stable in that cycle; address increments the following cycle.
- State transitions take effect the cycle after byte-valid; `cpu_hold` falls and `load_done` rises in the same cycle the FSM enters DONE.
- Back-to-back bytes (stop bit directly followed by start) are accepted: receiver rearms immediately after the stop-bit sample.
- Bit-timing counter width: $clog2(CLKS_PER_BIT); bit index 0..9 wraps to idle.

## Structure
- Package `loader_pkg`: FSM state enum, `SYNC_BYTE = 8'h55`.
- Sub-module `uart_rx` (synchronizer, bit timer, shift register, outputs `rx_data[7:0]`, `rx_valid`, `rx_ferr`); reusable by any future UART consumer. FSM and memory write logic in `uart_loader`.

## Test plan
- Reset: all outputs at reset values, `cpu_hold`=1; idle `rxd`=1 for 20 bit-times → no `mem_we`.
- Good load: 55 03 00 A9 01 00 AA (sum 0xAA) → writes A9@0, 01@1, 00@2, one `mem_we` each; `load_done`=1, `cpu_hold`=0.
- Bad checksum: 55 02 00 10 20 31 → two writes, then `load_err`=1, `cpu_hold`=1; follow with good frame → `load_done`=1, `load_err`=0.
- Length overflow: 55 01 04 (N=1025) → ERR with zero writes; N=0 frame 55 00 00 00 → DONE.
- Framing error: stop bit forced 0 on second data byte → no write for it, ERR; 3-clock low glitch on idle `rxd` → no byte detected.
- Reset mid-frame: assert `rst` during DATA byte 2 of a 5-byte image → outputs at reset values, next 0x55 starts fresh at address 0.
